// File: rtl/dyn_step_sequencer_if.sv
// AXI4-Lite master bundle between the step sequencer and the plant-dynamics register window.
interface dyn_step_sequencer_if #(
  parameter int C_M_AXI_ADDR_WIDTH = 4
);
  logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR;
  logic [2:0]                    M_AXI_AWPROT;
  logic                          M_AXI_AWVALID;
  logic                          M_AXI_AWREADY;
  logic [31:0]                   M_AXI_WDATA;
  logic [3:0]                    M_AXI_WSTRB;
  logic                          M_AXI_WVALID;
  logic                          M_AXI_WREADY;
  logic [1:0]                    M_AXI_BRESP;
  logic                          M_AXI_BVALID;
  logic                          M_AXI_BREADY;
  logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR;
  logic [2:0]                    M_AXI_ARPROT;
  logic                          M_AXI_ARVALID;
  logic                          M_AXI_ARREADY;
  logic [31:0]                   M_AXI_RDATA;
  logic [1:0]                    M_AXI_RRESP;
  logic                          M_AXI_RVALID;
  logic                          M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/dyn_step_sequencer.sv
// Periodic plant step: writes u0/u1 to the dynamics window, reads back two state words,
// and publishes them as y0/y1 with a one-cycle y_valid pulse.
module dyn_step_sequencer #(
  parameter int PERIOD             = 1000,
  parameter int C_M_AXI_ADDR_WIDTH = 4
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        enable,
  input  logic [31:0] u0,
  input  logic [31:0] u1,
  output logic [31:0] y0,
  output logic [31:0] y1,
  output logic        y_valid,
  output logic        busy,
  output logic        overrun,
  output logic        resp_err,
  input  logic        err_clr,
  dyn_step_sequencer_if.master m_axi
);

  localparam int CNT_W = $clog2(PERIOD);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR      = 3'd1;
  localparam logic [2:0] WR_RESP = 3'd2;
  localparam logic [2:0] RD      = 3'd3;
  localparam logic [2:0] RD_DATA = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic [2:0]       state;
  logic             idx;
  logic             aw_vld, w_vld, b_rdy, ar_vld, r_rdy;
  logic [31:0]      snap [2];
  logic [31:0]      hold [2];
  logic             wr_done, b_hs, r_hs, resp_set;

  assign tick     = enable && (cnt == CNT_W'(PERIOD - 1));
  assign busy     = (state != IDLE);
  assign wr_done  = (!aw_vld || m_axi.M_AXI_AWREADY) && (!w_vld || m_axi.M_AXI_WREADY);
  assign b_hs     = (state == WR_RESP) && m_axi.M_AXI_BVALID;
  assign r_hs     = (state == RD_DATA) && m_axi.M_AXI_RVALID;
  assign resp_set = (b_hs && (m_axi.M_AXI_BRESP != 2'b00)) ||
                    (r_hs && (m_axi.M_AXI_RRESP != 2'b00));

  assign m_axi.M_AXI_AWADDR  = C_M_AXI_ADDR_WIDTH'({idx, 2'b00});
  assign m_axi.M_AXI_AWPROT  = 3'b000;
  assign m_axi.M_AXI_AWVALID = aw_vld;
  assign m_axi.M_AXI_WDATA   = snap[idx];
  assign m_axi.M_AXI_WSTRB   = 4'b1111;
  assign m_axi.M_AXI_WVALID  = w_vld;
  assign m_axi.M_AXI_BREADY  = b_rdy;
  assign m_axi.M_AXI_ARADDR  = C_M_AXI_ADDR_WIDTH'({1'b1, idx, 2'b00});
  assign m_axi.M_AXI_ARPROT  = 3'b000;
  assign m_axi.M_AXI_ARVALID = ar_vld;
  assign m_axi.M_AXI_RREADY  = r_rdy;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cnt <= '0;
    end else if (!enable || (cnt == CNT_W'(PERIOD - 1))) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Data-only registers: snapshot of the controls and the read-back holding pair
  always_ff @(posedge ACLK) begin
    if ((state == IDLE) && tick) begin
      snap[0] <= u0;
      snap[1] <= u1;
    end
    if (r_hs) hold[idx] <= m_axi.M_AXI_RDATA;
  end

  // Sticky flags: a set event in the same cycle as err_clr keeps the flag high
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      overrun  <= 1'b0;
      resp_err <= 1'b0;
    end else begin
      if (tick && busy)  overrun <= 1'b1;
      else if (err_clr)  overrun <= 1'b0;
      if (resp_set)      resp_err <= 1'b1;
      else if (err_clr)  resp_err <= 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state   <= IDLE;
      idx     <= 1'b0;
      aw_vld  <= 1'b0;
      w_vld   <= 1'b0;
      b_rdy   <= 1'b0;
      ar_vld  <= 1'b0;
      r_rdy   <= 1'b0;
      y0      <= '0;
      y1      <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            idx    <= 1'b0;
            aw_vld <= 1'b1;
            w_vld  <= 1'b1;
            state  <= WR;
          end
        end
        WR: begin
          if (aw_vld && m_axi.M_AXI_AWREADY) aw_vld <= 1'b0;
          if (w_vld && m_axi.M_AXI_WREADY)   w_vld  <= 1'b0;
          if (wr_done) begin
            b_rdy <= 1'b1;
            state <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_axi.M_AXI_BVALID) begin
            b_rdy <= 1'b0;
            if (!idx) begin
              idx    <= 1'b1;
              aw_vld <= 1'b1;
              w_vld  <= 1'b1;
              state  <= WR;
            end else begin
              idx    <= 1'b0;
              ar_vld <= 1'b1;
              state  <= RD;
            end
          end
        end
        RD: begin
          if (m_axi.M_AXI_ARREADY) begin
            ar_vld <= 1'b0;
            r_rdy  <= 1'b1;
            state  <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_axi.M_AXI_RVALID) begin
            r_rdy <= 1'b0;
            if (!idx) begin
              idx    <= 1'b1;
              ar_vld <= 1'b1;
              state  <= RD;
            end else begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          y0      <= hold[0];
          y1      <= hold[1];
          y_valid <= 1'b1;
          idx     <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dyn_step_sequencer.sv
// Directed bench for dyn_step_sequencer with a small AXI4-Lite slave model driven on the falling edge.
module tb_dyn_step_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        err_clr;
  logic [31:0] u0, u1;
  logic [31:0] y0, y1;
  logic        y_valid, busy, overrun, resp_err;

  dyn_step_sequencer_if #(.C_M_AXI_ADDR_WIDTH(4)) axi ();

  dyn_step_sequencer #(.PERIOD(16), .C_M_AXI_ADDR_WIDTH(4)) dut (
    .ACLK     (clk),
    .ARESETN  (rst_n),
    .enable   (enable),
    .u0       (u0),
    .u1       (u1),
    .y0       (y0),
    .y1       (y1),
    .y_valid  (y_valid),
    .busy     (busy),
    .overrun  (overrun),
    .resp_err (resp_err),
    .err_clr  (err_clr),
    .m_axi    (axi)
  );

  always #5 clk = ~clk;

  int          passed = 0;
  int          failed = 0;
  int          total  = 0;

  int          aw_delay = 0, w_delay = 0, r_delay = 0;
  logic [1:0]  rresp_c = 2'b00;
  logic [31:0] mem8 = 32'h0, memc = 32'h0;

  logic        hs_aw, hs_w, hs_b, hs_ar, hs_r;
  logic        aw_got, w_got, r_pend;
  int          aw_cnt, w_cnt, r_cnt;
  logic [3:0]  aw_cap, ar_cap;
  logic [31:0] w_cap;
  logic [3:0]  wa [64];
  logic [31:0] wd [64];
  logic [3:0]  ra [64];
  int          nwr = 0, nrd = 0, yv_cnt = 0, cyc = 0;

  // Slave model: decides READY/VALID on the falling edge; handshakes complete on the next rising edge
  initial begin
    axi.M_AXI_AWREADY = 1'b0; axi.M_AXI_WREADY = 1'b0;
    axi.M_AXI_BVALID  = 1'b0; axi.M_AXI_BRESP  = 2'b00;
    axi.M_AXI_ARREADY = 1'b0; axi.M_AXI_RVALID = 1'b0;
    axi.M_AXI_RDATA   = 32'h0; axi.M_AXI_RRESP = 2'b00;
    hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
    aw_got = 0; w_got = 0; r_pend = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0;
    aw_cap = '0; ar_cap = '0; w_cap = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (y_valid) yv_cnt++;
      if (!rst_n) begin
        axi.M_AXI_AWREADY = 1'b0; axi.M_AXI_WREADY = 1'b0; axi.M_AXI_BVALID = 1'b0;
        axi.M_AXI_ARREADY = 1'b0; axi.M_AXI_RVALID = 1'b0;
        hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
        aw_got = 0; w_got = 0; r_pend = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0;
      end else begin
        if (hs_aw) aw_got = 1'b1;
        if (hs_w)  w_got  = 1'b1;
        if (hs_b)  axi.M_AXI_BVALID = 1'b0;
        if (hs_ar) begin r_pend = 1'b1; r_cnt = 0; end
        if (hs_r)  axi.M_AXI_RVALID = 1'b0;

        if (axi.M_AXI_AWVALID && aw_cnt >= aw_delay) axi.M_AXI_AWREADY = 1'b1;
        else begin
          axi.M_AXI_AWREADY = 1'b0;
          aw_cnt = axi.M_AXI_AWVALID ? aw_cnt + 1 : 0;
        end
        if (axi.M_AXI_WVALID && w_cnt >= w_delay) axi.M_AXI_WREADY = 1'b1;
        else begin
          axi.M_AXI_WREADY = 1'b0;
          w_cnt = axi.M_AXI_WVALID ? w_cnt + 1 : 0;
        end

        if (aw_got && w_got && !axi.M_AXI_BVALID) begin
          axi.M_AXI_BVALID = 1'b1;
          axi.M_AXI_BRESP  = 2'b00;
          aw_got = 1'b0; w_got = 1'b0;
          wa[nwr] = aw_cap; wd[nwr] = w_cap; nwr++;
        end

        axi.M_AXI_ARREADY = axi.M_AXI_ARVALID;
        if (r_pend) begin
          if (r_cnt >= r_delay) begin
            axi.M_AXI_RVALID = 1'b1;
            axi.M_AXI_RDATA  = (ar_cap == 4'h8) ? mem8 : memc;
            axi.M_AXI_RRESP  = (ar_cap == 4'hC) ? rresp_c : 2'b00;
            r_pend = 1'b0;
            ra[nrd] = ar_cap; nrd++;
          end else begin
            r_cnt++;
          end
        end

        hs_aw = axi.M_AXI_AWVALID && axi.M_AXI_AWREADY;
        if (hs_aw) aw_cap = axi.M_AXI_AWADDR;
        hs_w  = axi.M_AXI_WVALID && axi.M_AXI_WREADY;
        if (hs_w) w_cap = axi.M_AXI_WDATA;
        hs_b  = axi.M_AXI_BVALID && axi.M_AXI_BREADY;
        hs_ar = axi.M_AXI_ARVALID && axi.M_AXI_ARREADY;
        if (hs_ar) ar_cap = axi.M_AXI_ARADDR;
        hs_r  = axi.M_AXI_RVALID && axi.M_AXI_RREADY;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_busy(input string tag, input int budget);
    int k;
    k = 0;
    while (!busy && k < budget) begin step(1); k++; end
    check(tag, 32'(busy), 32'd1);
  endtask

  task automatic wait_yv(input string tag, input int budget);
    int k;
    k = 0;
    while (!y_valid && k < budget) begin step(1); k++; end
    check(tag, 32'(y_valid), 32'd1);
  endtask

  initial begin
    int n0w, n0r, yb, t_s, t_n, k;
    rst_n = 1'b0; enable = 1'b0; err_clr = 1'b0; u0 = '0; u1 = '0;
    mem8 = 32'h1234; memc = 32'h5678;
    step(3);
    check("rst_handshake", 32'({axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY,
                                axi.M_AXI_ARVALID, axi.M_AXI_RREADY}), 32'd0);
    check("rst_flags", 32'({busy, overrun, resp_err, y_valid}), 32'd0);
    check("rst_y0", y0, 32'd0);
    check("rst_y1", y1, 32'd0);
    check("rst_cnt", 32'(dut.cnt), 32'd0);

    // Out of reset with enable low: nothing happens
    rst_n = 1'b1;
    step(20);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_writes", 32'(nwr), 32'd0);

    // Basic step, zero-wait slave
    u0 = 32'h11; u1 = 32'h22;
    n0w = nwr; n0r = nrd; yb = yv_cnt;
    enable = 1'b1;
    step(15);
    check("t1_before_tick", 32'(busy), 32'd0);
    step(1);
    check("t1_tick_busy", 32'(busy), 32'd1);
    check("t1_wr_valids", 32'({axi.M_AXI_AWVALID, axi.M_AXI_WVALID}), 32'd3);
    check("t1_awaddr0", 32'(axi.M_AXI_AWADDR), 32'h0);
    check("t1_wdata0", axi.M_AXI_WDATA, 32'h11);
    wait_yv("t1_yvalid", 40);
    enable = 1'b0;
    check("t1_y0", y0, 32'h1234);
    check("t1_y1", y1, 32'h5678);
    check("t1_wa0", 32'(wa[n0w]), 32'h0);
    check("t1_wd0", wd[n0w], 32'h11);
    check("t1_wa1", 32'(wa[n0w+1]), 32'h4);
    check("t1_wd1", wd[n0w+1], 32'h22);
    check("t1_ra0", 32'(ra[n0r]), 32'h8);
    check("t1_ra1", 32'(ra[n0r+1]), 32'hC);
    check("t1_nwr", 32'(nwr - n0w), 32'd2);
    check("t1_nrd", 32'(nrd - n0r), 32'd2);
    step(3);
    check("t1_one_pulse", 32'(yv_cnt - yb), 32'd1);
    check("t1_idle_flags", 32'({busy, overrun, resp_err}), 32'd0);

    // AWREADY delayed 3 cycles, WREADY immediate
    aw_delay = 3;
    u0 = 32'hA5; u1 = 32'h5A;
    mem8 = 32'hDEAD0001; memc = 32'hBEEF0002;
    n0w = nwr;
    enable = 1'b1;
    wait_busy("t2_start", 20);
    check("t2_c0", 32'({axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY}), 32'b110);
    step(1);
    check("t2_c1", 32'({axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY}), 32'b100);
    step(1);
    check("t2_c2", 32'({axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY}), 32'b100);
    step(1);
    check("t2_c3", 32'({axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY}), 32'b100);
    step(1);
    check("t2_c4", 32'({axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY}), 32'b001);
    wait_yv("t2_yvalid", 60);
    enable = 1'b0;
    check("t2_y0", y0, 32'hDEAD0001);
    check("t2_y1", y1, 32'hBEEF0002);
    check("t2_wa1", 32'(wa[n0w+1]), 32'h4);
    check("t2_wd1", wd[n0w+1], 32'h5A);
    aw_delay = 0;
    step(3);

    // Read stall longer than the period: overrun, single completion, next step on the later tick
    r_delay = 20;
    yb = yv_cnt;
    enable = 1'b1;
    wait_busy("t3_start", 20);
    t_s = cyc;
    wait_yv("t3_yvalid", 120);
    step(2);
    check("t3_overrun", 32'(overrun), 32'd1);
    check("t3_one_pulse", 32'(yv_cnt - yb), 32'd1);
    r_delay = 0;
    wait_busy("t3_next_start", 40);
    t_n = cyc;
    check("t3_next_tick", 32'(t_n - t_s), 32'd64);
    wait_yv("t3_next_yvalid", 40);
    enable = 1'b0;
    step(2);

    // Error flags
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("t4_overrun_clr", 32'(overrun), 32'd0);
    rresp_c = 2'b10;
    memc = 32'h77;
    enable = 1'b1;
    wait_busy("t4_start", 20);
    wait_yv("t4_yvalid", 60);
    enable = 1'b0;
    check("t4_resp_err", 32'(resp_err), 32'd1);
    check("t4_y1_used", y1, 32'h77);
    check("t4_y0", y0, 32'hDEAD0001);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("t4_err_clr", 32'(resp_err), 32'd0);
    enable = 1'b1;
    k = 0;
    while (!(axi.M_AXI_RVALID && axi.M_AXI_RREADY && axi.M_AXI_ARADDR == 4'hC) && k < 60) begin
      step(1); k++;
    end
    check("t4_sync", 32'(axi.M_AXI_RVALID && axi.M_AXI_RREADY), 32'd1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("t4_set_wins", 32'(resp_err), 32'd1);
    wait_yv("t4_yvalid2", 10);
    enable = 1'b0;
    rresp_c = 2'b00;
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("t4_err_clr2", 32'(resp_err), 32'd0);
    step(3);

    // Asynchronous reset in the middle of a write
    aw_delay = 5;
    u0 = 32'h33; u1 = 32'h44;
    enable = 1'b1;
    wait_busy("t5_start", 20);
    check("t5_in_wr", 32'({axi.M_AXI_AWVALID, axi.M_AXI_WVALID}), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_valids_drop", 32'({axi.M_AXI_AWVALID, axi.M_AXI_WVALID}), 32'd0);
    check("t5_busy_drop", 32'(busy), 32'd0);
    check("t5_y0_reset", y0, 32'd0);
    enable = 1'b0;
    step(2);
    rst_n = 1'b1;
    aw_delay = 0;
    n0w = nwr;
    step(20);
    check("t5_stays_idle", 32'({busy, axi.M_AXI_AWVALID}), 32'd0);
    enable = 1'b1;
    wait_busy("t5_resume", 20);
    wait_yv("t5_yvalid", 60);
    enable = 1'b0;
    check("t5_nwr", 32'(nwr - n0w), 32'd2);
    check("t5_wd0", wd[n0w], 32'h33);
    check("t5_wd1", wd[n0w+1], 32'h44);
    check("t5_y1", y1, 32'h77);
    step(3);

    // enable dropped during the read phase
    u0 = 32'h66; u1 = 32'h99;
    mem8 = 32'h1111; memc = 32'h2222;
    enable = 1'b1;
    k = 0;
    while (!axi.M_AXI_ARVALID && k < 40) begin step(1); k++; end
    check("t6_in_rd", 32'(axi.M_AXI_ARVALID), 32'd1);
    enable = 1'b0;
    wait_yv("t6_yvalid", 40);
    check("t6_y0", y0, 32'h1111);
    check("t6_y1", y1, 32'h2222);
    n0w = nwr; n0r = nrd;
    step(40);
    check("t6_no_traffic", 32'((nwr - n0w) + (nrd - n0r)), 32'd0);
    check("t6_idle", 32'(busy), 32'd0);
    check("t6_cnt_zero", 32'(dut.cnt), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
